// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALUOp codes, mux selects, FSM states and control word for the multicycle controller.
package ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BLT   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BLT  = 2'b10;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPEEX, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;
    typedef struct packed {
        logic       pcwrite;
        logic [1:0] branch;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;
    function automatic logic op_known(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BLT, OP_ADDI, OP_J};
    endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the multicycle controller (master) and its datapath (slave).
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite;
    logic [1:0] branch;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       instr_done;
    logic       illegal_op;
    modport master (
        input  op, mem_ready,
        output pcwrite, branch, iord, irwrite, memwrite, memtoreg, regdst, regwrite,
               alusrca, alusrcb, pcsrc, aluop, instr_done, illegal_op
    );
    modport slave (
        output op, mem_ready,
        input  pcwrite, branch, iord, irwrite, memwrite, memtoreg, regdst, regwrite,
               alusrca, alusrcb, pcsrc, aluop, instr_done, illegal_op
    );
endinterface

// File: rtl/mc_outdec.sv
// mc_outdec: ungated state -> control word decode; memory-ready and reset gating happen in the top.
module mc_outdec
    import ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] op_i,
    output ctrl_t      cw_o
);
    always_comb begin
        cw_o = '0;
        case (state_i)
            S_FETCH: begin
                cw_o.alusrcb = SRCB_FOUR;
                cw_o.irwrite = 1'b1;
                cw_o.pcwrite = 1'b1;
            end
            S_DECODE: begin
                cw_o.alusrcb    = SRCB_IMMSH;
                cw_o.illegal_op = !op_known(op_i);
            end
            S_MEMADR, S_ADDIEX: begin
                cw_o.alusrca = 1'b1;
                cw_o.alusrcb = SRCB_IMM;
            end
            S_MEMRD: cw_o.iord = 1'b1;
            S_MEMWB: begin
                cw_o.memtoreg   = 1'b1;
                cw_o.regwrite   = 1'b1;
                cw_o.instr_done = 1'b1;
            end
            S_MEMWR: begin
                cw_o.iord       = 1'b1;
                cw_o.memwrite   = 1'b1;
                cw_o.instr_done = 1'b1;
            end
            S_RTYPEEX: begin
                cw_o.alusrca = 1'b1;
                cw_o.alusrcb = SRCB_REG;
                cw_o.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                cw_o.regdst     = 1'b1;
                cw_o.regwrite   = 1'b1;
                cw_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                cw_o.alusrca    = 1'b1;
                cw_o.aluop      = ALUOP_SUB;
                cw_o.pcsrc      = PCSRC_ALUOUT;
                cw_o.branch     = op_i == OP_BEQ ? BR_BEQ : op_i == OP_BLT ? BR_BLT : BR_NONE;
                cw_o.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                cw_o.regwrite   = 1'b1;
                cw_o.instr_done = 1'b1;
            end
            S_JUMP: begin
                cw_o.pcsrc      = PCSRC_JUMP;
                cw_o.pcwrite    = 1'b1;
                cw_o.instr_done = 1'b1;
            end
            default: cw_o = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS-subset control FSM with memory-ready wait states.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    state_t state_q, state_d;
    ctrl_t  cw;
    logic   rdy_gate;
    mc_outdec u_outdec (.state_i(state_q), .op_i(bus.op), .cw_o(cw));
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_RTYPE:      state_d = S_RTYPEEX;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ, OP_BLT: state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_ADDIEX;
                    OP_J:          state_d = S_JUMP;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = bus.op == OP_SW ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end
    // Strobes that complete a memory access wait for mem_ready; reset masks every write strobe.
    assign rdy_gate       = reset & (state_q inside {S_FETCH, S_MEMRD, S_MEMWR} ? bus.mem_ready : 1'b1);
    assign bus.pcwrite    = cw.pcwrite & rdy_gate;
    assign bus.irwrite    = cw.irwrite & rdy_gate;
    assign bus.instr_done = cw.instr_done & rdy_gate;
    assign bus.memwrite   = cw.memwrite & reset;
    assign bus.regwrite   = cw.regwrite & reset;
    assign bus.illegal_op = cw.illegal_op & reset;
    assign bus.branch     = cw.branch & {2{reset}};
    assign bus.iord       = cw.iord;
    assign bus.memtoreg   = cw.memtoreg;
    assign bus.regdst     = cw.regdst;
    assign bus.alusrca    = cw.alusrca;
    assign bus.alusrcb    = cw.alusrcb;
    assign bus.pcsrc      = cw.pcsrc;
    assign bus.aluop      = cw.aluop;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-cycle vector table plus latency/wait-state sequences for multicycle_ctrl.
module tb_multicycle_ctrl;
    typedef struct packed {
        logic       pcwrite;
        logic [1:0] branch;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       instr_done;
        logic       illegal_op;
    } exp_t;
    typedef struct {
        string      name;
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        exp_t       e;
    } vec_t;
    localparam logic [5:0] LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, BLT = 6'h05;
    localparam logic [5:0] ADDI = 6'h08, JMP = 6'h02, RT = 6'h00, BAD = 6'h3F;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    vec_t v[$];
    multicycle_ctrl_if bus ();
    multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    function automatic exp_t fe(input logic r);
        exp_t e = '0;
        e.pcwrite = r; e.irwrite = r; e.alusrcb = 2'b01;
        return e;
    endfunction
    function automatic exp_t de(input logic ill);
        exp_t e = '0;
        e.alusrcb = 2'b11; e.illegal_op = ill;
        return e;
    endfunction
    function automatic exp_t ma();
        exp_t e = '0;
        e.alusrca = 1'b1; e.alusrcb = 2'b10;
        return e;
    endfunction
    function automatic exp_t mr();
        exp_t e = '0;
        e.iord = 1'b1;
        return e;
    endfunction
    function automatic exp_t mwb();
        exp_t e = '0;
        e.memtoreg = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1;
        return e;
    endfunction
    function automatic exp_t mw(input logic r);
        exp_t e = '0;
        e.iord = 1'b1; e.memwrite = 1'b1; e.instr_done = r;
        return e;
    endfunction
    function automatic exp_t rx();
        exp_t e = '0;
        e.alusrca = 1'b1; e.aluop = 2'b10;
        return e;
    endfunction
    function automatic exp_t awb();
        exp_t e = '0;
        e.regdst = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1;
        return e;
    endfunction
    function automatic exp_t br(input logic [1:0] b);
        exp_t e = '0;
        e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.branch = b; e.instr_done = 1'b1;
        return e;
    endfunction
    function automatic exp_t iwb();
        exp_t e = '0;
        e.regwrite = 1'b1; e.instr_done = 1'b1;
        return e;
    endfunction
    function automatic exp_t jp();
        exp_t e = '0;
        e.pcsrc = 2'b10; e.pcwrite = 1'b1; e.instr_done = 1'b1;
        return e;
    endfunction
    function automatic exp_t act();
        return {bus.pcwrite, bus.branch, bus.iord, bus.irwrite, bus.memwrite, bus.memtoreg,
                bus.regdst, bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.aluop,
                bus.instr_done, bus.illegal_op};
    endfunction
    task automatic add(input string n, input logic r, input logic [5:0] op, input logic rdy, input exp_t e);
        vec_t t;
        t.name = n; t.rst = r; t.op = op; t.rdy = rdy; t.e = e;
        v.push_back(t);
    endtask
    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", n, got, want);
        end
    endtask
    task automatic latency(input string n, input logic [5:0] op, input int want);
        int cyc = 0;
        logic done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            bus.op = op; bus.mem_ready = 1'b1;
            #1;
            cyc++;
            done = bus.instr_done;
        end
        chk(n, cyc, want);
    endtask
    initial begin
        int waits, mwc;
        logic done;
        bus.op = LW; bus.mem_ready = 1'b1;
        add("reset_hold",   0, LW,  1, fe(0));
        add("reset_hold2",  0, LW,  1, fe(0));
        add("lw_fetch",     1, LW,  1, fe(1));
        add("lw_decode",    1, LW,  1, de(0));
        add("lw_memadr",    1, LW,  1, ma());
        add("lw_memrd",     1, LW,  1, mr());
        add("lw_memwb",     1, LW,  1, mwb());
        add("sw_fetch",     1, SW,  1, fe(1));
        add("sw_decode",    1, SW,  1, de(0));
        add("sw_memadr",    1, SW,  1, ma());
        add("sw_wait1",     1, SW,  0, mw(0));
        add("sw_wait2",     1, SW,  0, mw(0));
        add("sw_wait3",     1, SW,  0, mw(0));
        add("sw_done",      1, SW,  1, mw(1));
        add("beq_fetch",    1, BEQ, 1, fe(1));
        add("beq_decode",   1, BEQ, 0, de(0));
        add("beq_branch",   1, BEQ, 0, br(2'b01));
        add("blt_fetch",    1, BLT, 1, fe(1));
        add("blt_decode",   1, BLT, 1, de(0));
        add("blt_branch",   1, BLT, 1, br(2'b10));
        add("j_fetch",      1, JMP, 1, fe(1));
        add("j_decode",     1, JMP, 1, de(0));
        add("j_jump",       1, JMP, 1, jp());
        add("addi_fetch",   1, ADDI, 1, fe(1));
        add("addi_decode",  1, ADDI, 1, de(0));
        add("addi_ex",      1, ADDI, 0, ma());
        add("addi_wb",      1, ADDI, 0, iwb());
        add("r_fetch",      1, RT,  1, fe(1));
        add("r_decode",     1, RT,  1, de(0));
        add("r_ex",         1, RT,  1, rx());
        add("r_wb",         1, RT,  1, awb());
        add("bad_fetch",    1, BAD, 1, fe(1));
        add("bad_decode",   1, BAD, 1, de(1));
        add("after_bad_f",  1, LW,  0, fe(0));
        add("fetch_stall",  1, LW,  0, fe(0));
        add("fetch_go",     1, LW,  1, fe(1));
        add("lwd_decode",   1, LW,  0, de(0));
        add("lwd_memadr",   1, LW,  0, ma());
        add("lwd_rdwait",   1, LW,  0, mr());
        add("lwd_rdgo",     1, LW,  1, mr());
        add("lwd_wb",       1, LW,  0, mwb());
        add("swr_fetch",    1, SW,  1, fe(1));
        add("swr_decode",   1, SW,  1, de(0));
        add("swr_memadr",   1, SW,  1, ma());
        add("swr_wait",     1, SW,  0, mw(0));
        add("swr_reset",    0, SW,  0, fe(0));
        add("swr_reset2",   0, SW,  1, fe(0));
        add("rel_stall1",   1, SW,  0, fe(0));
        add("rel_stall2",   1, SW,  0, fe(0));
        add("rel_go",       1, LW,  1, fe(1));
        add("rel_decode",   1, LW,  1, de(0));
        add("rel_memadr",   1, LW,  1, ma());
        add("rel_memrd",    1, LW,  1, mr());
        add("rel_memwb",    1, LW,  1, mwb());
        foreach (v[i]) begin
            @(negedge clk);
            reset = v[i].rst; bus.op = v[i].op; bus.mem_ready = v[i].rdy;
            #1;
            chk(v[i].name, act(), v[i].e);
        end
        latency("lat_lw",   LW,   5);
        latency("lat_sw",   SW,   4);
        latency("lat_r",    RT,   4);
        latency("lat_addi", ADDI, 4);
        latency("lat_beq",  BEQ,  3);
        latency("lat_j",    JMP,  3);
        latency("lat_bad_then_j", BAD, 20);
        waits = 0; mwc = 0; done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            bus.op = SW; bus.mem_ready = 1'b1;
            #1;
            if (bus.memwrite && waits < 3) begin
                bus.mem_ready = 1'b0;
                waits++;
            end
            #1;
            if (bus.memwrite) mwc++;
            if (bus.instr_done) begin
                done = 1'b1;
                chk("sw_done_rdy", bus.mem_ready, 1);
            end
        end
        chk("sw_memwrite_cycles", mwc, 4);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk("sw_next_fetch", act(), fe(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
